// File: rtl/blkop_seq.sv
// blkop_seq: block INC/ENC/DEC/COPY engine that walks LEN words through
// a single-port memory shared with the CPU (CPU first, starvation-bounded).
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   start, op, src, dst  operation request (sampled in IDLE)
//   busy, done           status / one-cycle completion pulse
//   cpu_*                CPU load/store side of the shared port
//   mem_*                single-port synchronous memory side
module blkop_seq #(
  parameter int unsigned    DW     = 19,
  parameter int unsigned    AW     = 19,
  parameter int unsigned    LEN    = 8,
  parameter logic [DW-1:0]  KEY    = 19'h1999F,
  parameter int unsigned    STARVE = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    op,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  output logic          busy,
  output logic          done,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned IW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int unsigned SW = $clog2(STARVE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_op;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [IW-1:0] r_idx;
  logic [DW-1:0] r_word;
  logic [SW-1:0] r_starve;
  logic          r_rvalid;

  logic          w_eng_req;
  logic          w_force;
  logic          w_cpu_gnt;
  logic          w_eng_gnt;
  logic          w_last;
  logic [AW-1:0] w_idx_ext;

  assign w_eng_req = (r_state == S_RD) || (r_state == S_WR);
  assign w_force   = w_eng_req && (r_starve == SW'(STARVE));
  // Grants are qualified with rst_n so nothing reaches memory during reset.
  assign w_cpu_gnt = rst_n && cpu_req && !w_force;
  assign w_eng_gnt = rst_n && w_eng_req && !w_cpu_gnt;
  assign w_last    = (r_idx == IW'(LEN - 1));
  assign w_idx_ext = AW'(r_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (start) w_next = S_RD;
      S_RD:   if (w_eng_gnt) w_next = S_CAP;
      S_CAP:  w_next = S_WR;
      S_WR: begin
        if (w_eng_gnt) w_next = w_last ? S_DONE : S_RD;
      end
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op     <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_idx    <= '0;
      r_word   <= '0;
      r_starve <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= w_cpu_gnt && !cpu_we;

      if (r_state == S_IDLE && start) begin
        r_op  <= op;
        r_src <= src;
        r_dst <= dst;
        r_idx <= '0;
      end else if (r_state == S_WR && w_eng_gnt && !w_last) begin
        r_idx <= r_idx + IW'(1);
      end

      if (r_state == S_CAP) begin
        unique case (r_op)
          2'b00:   r_word <= mem_rdata + DW'(1);
          2'b01:   r_word <= mem_rdata ^ KEY;
          2'b10:   r_word <= mem_rdata ^ KEY;
          default: r_word <= mem_rdata;
        endcase
      end

      // Counts denied request cycles; any grant or non-request clears it.
      if (w_eng_req && !w_eng_gnt) begin
        if (r_starve != SW'(STARVE)) r_starve <= r_starve + SW'(1);
      end else begin
        r_starve <= '0;
      end
    end
  end

  always_comb begin
    busy      = (r_state == S_RD) || (r_state == S_CAP) ||
                (r_state == S_WR);
    done      = (r_state == S_DONE);
    cpu_gnt   = w_cpu_gnt;
    cpu_rvalid = r_rvalid;
    cpu_rdata = rst_n ? mem_rdata : '0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (w_cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (w_eng_gnt) begin
      mem_en = 1'b1;
      if (r_state == S_WR) begin
        mem_we    = 1'b1;
        mem_addr  = r_dst + w_idx_ext;
        mem_wdata = r_word;
      end else begin
        mem_addr = r_src + w_idx_ext;
      end
    end
  end

endmodule

// File: tb/tb_blkop_seq.sv
// tb_blkop_seq: directed scenarios for blkop_seq with a behavioural
// single-port memory; expected values are hand-computed constants.
module tb_blkop_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [18:0] src = '0;
  logic [18:0] dst = '0;
  logic        busy, done;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [18:0] cpu_wdata = '0;
  logic        cpu_gnt;
  logic [18:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        mem_en, mem_we;
  logic [18:0] mem_addr, mem_wdata;
  logic [18:0] mem_rdata = '0;

  logic [18:0] mem [0:(1<<19)-1];
  logic        bd_we = 1'b0;
  logic [18:0] bd_addr = '0;
  logic [18:0] bd_data = '0;
  logic        log_clr = 1'b0;
  logic [18:0] rd_log[$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  blkop_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .src(src), .dst(dst), .busy(busy), .done(done),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata),
    .cpu_rvalid(cpu_rvalid), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk) begin
    if (bd_we) mem[bd_addr] <= bd_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else mem_rdata <= mem[mem_addr];
    end
  end

  always @(posedge clk) begin
    if (log_clr) rd_log.delete();
    else if (mem_en && !mem_we && !cpu_gnt) rd_log.push_back(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic poke(input logic [18:0] a, input logic [18:0] d);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic clr_log();
    @(posedge clk); #1;
    log_clr = 1'b1;
    @(posedge clk); #1;
    log_clr = 1'b0;
  endtask

  // Start at cycle T=0, then scramble op/src/dst to prove they were latched.
  task automatic run_op(input logic [1:0] o, input logic [18:0] s,
                        input logic [18:0] d, input bit restart,
                        output int busy_n, output int done_at,
                        output int done_n);
    @(posedge clk); #1;
    start = 1'b1; op = o; src = s; dst = d;
    busy_n = 0; done_at = 0; done_n = 0;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      start = 1'b0; op = ~o; src = '0; dst = '0;
      if (restart && (c == 5 || c == 25)) begin
        start = 1'b1; op = 2'b11; src = 19'h600; dst = 19'h700;
      end
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at == 0) done_at = c;
      end
      if (done_at != 0 && c > done_at) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h10;
    #12;
    n_vec++;
    if ({busy, done, cpu_rvalid, mem_en, mem_we, cpu_gnt} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_outputs got=%b exp=000000",
               {busy, done, cpu_rvalid, mem_en, mem_we, cpu_gnt});
    end
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL idle_after_reset busy=%b done=%b exp 0/0", busy, done);
    end
  endtask

  task automatic test_inc();
    int b, da, dn;
    for (int i = 0; i < 8; i++) poke(19'h100 + 19'(i), 19'(i));
    run_op(2'b00, 19'h100, 19'h200, 1'b0, b, da, dn);
    n_vec++;
    if (b !== 24) begin
      n_err++; $display("FAIL inc_busy_cycles got=%0d exp=24", b);
    end
    n_vec++;
    if (da !== 25) begin
      n_err++; $display("FAIL inc_done_cycle got=%0d exp=25", da);
    end
    n_vec++;
    if (dn !== 1) begin
      n_err++; $display("FAIL inc_done_count got=%0d exp=1", dn);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (mem[19'h200 + 19'(i)] !== 19'(i + 1)) begin
        n_err++;
        $display("FAIL inc_word%0d got=%h exp=%h", i,
                 mem[19'h200 + 19'(i)], 19'(i + 1));
      end
    end
  endtask

  task automatic test_wrap();
    int b, da, dn;
    logic [18:0] exp_rd [8];
    logic [18:0] exp_wr [8];
    exp_rd = '{19'h7FFFC, 19'h7FFFD, 19'h7FFFE, 19'h7FFFF,
               19'h00000, 19'h00001, 19'h00002, 19'h00003};
    exp_wr = '{19'h00000, 19'h00002, 19'h00003, 19'h00004,
               19'h00005, 19'h00006, 19'h00007, 19'h00008};
    poke(19'h7FFFC, 19'h7FFFF);
    poke(19'h7FFFD, 19'h1);
    poke(19'h7FFFE, 19'h2);
    poke(19'h7FFFF, 19'h3);
    for (int i = 0; i < 4; i++) poke(19'(i), 19'(i + 4));
    clr_log();
    run_op(2'b00, 19'h7FFFC, 19'h1000, 1'b0, b, da, dn);
    n_vec++;
    if (rd_log.size() !== 8) begin
      n_err++; $display("FAIL wrap_read_count got=%0d exp=8", rd_log.size());
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (i < rd_log.size() && rd_log[i] !== exp_rd[i]) begin
        n_err++;
        $display("FAIL wrap_read_addr%0d got=%h exp=%h", i, rd_log[i],
                 exp_rd[i]);
      end
      n_vec++;
      if (mem[19'h1000 + 19'(i)] !== exp_wr[i]) begin
        n_err++;
        $display("FAIL wrap_word%0d got=%h exp=%h", i,
                 mem[19'h1000 + 19'(i)], exp_wr[i]);
      end
    end
  endtask

  task automatic test_enc_dec();
    int b, da, dn;
    for (int i = 0; i < 8; i++) poke(19'h100 + 19'(i), 19'h00005);
    run_op(2'b01, 19'h100, 19'h300, 1'b0, b, da, dn);
    n_vec++;
    if (da !== 25) begin
      n_err++; $display("FAIL enc_done_cycle got=%0d exp=25", da);
    end
    run_op(2'b10, 19'h300, 19'h400, 1'b0, b, da, dn);
    n_vec++;
    if (b !== 24) begin
      n_err++; $display("FAIL dec_busy_cycles got=%0d exp=24", b);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (mem[19'h300 + 19'(i)] !== 19'h1999A) begin
        n_err++;
        $display("FAIL enc_word%0d got=%h exp=1999a", i,
                 mem[19'h300 + 19'(i)]);
      end
      n_vec++;
      if (mem[19'h400 + 19'(i)] !== 19'h00005) begin
        n_err++;
        $display("FAIL dec_word%0d got=%h exp=00005", i,
                 mem[19'h400 + 19'(i)]);
      end
    end
  endtask

  task automatic test_start_ignored();
    int b, da, dn;
    poke(19'h700, 19'h0ABCD);
    run_op(2'b00, 19'h100, 19'h900, 1'b1, b, da, dn);
    n_vec++;
    if (dn !== 1) begin
      n_err++; $display("FAIL restart_done_count got=%0d exp=1", dn);
    end
    n_vec++;
    if (da !== 25 || b !== 24) begin
      n_err++;
      $display("FAIL restart_timing done=%0d busy=%0d exp 25/24", da, b);
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++; $display("FAIL restart_idle busy=%b exp=0", busy);
    end
    n_vec++;
    if (mem[19'h700] !== 19'h0ABCD) begin
      n_err++;
      $display("FAIL restart_dst_untouched got=%h exp=0abcd", mem[19'h700]);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (mem[19'h900 + 19'(i)] !== 19'h00006) begin
        n_err++;
        $display("FAIL restart_word%0d got=%h exp=00006", i,
                 mem[19'h900 + 19'(i)]);
      end
    end
  endtask

  // Per word: 5 RD cycles (grant on 5th), 1 CAP, 5 WR (grant on 5th).
  task automatic test_contention();
    int n, da, dn, gbad, rbad, dbad;
    logic exp_g, prev;
    poke(19'h50, 19'h12345);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b01; src = 19'h100; dst = 19'h800;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h50;
    n = 0; da = 0; dn = 0; gbad = 0; rbad = 0; dbad = 0;
    prev = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (busy) n++;
      exp_g = !(busy && ((n - 1) % 11 == 4 || (n - 1) % 11 == 10));
      n_vec++;
      if (cpu_gnt !== exp_g) begin
        n_err++; gbad++;
        if (gbad < 4)
          $display("FAIL cont_gnt c=%0d got=%b exp=%b", c, cpu_gnt, exp_g);
      end
      n_vec++;
      if (cpu_rvalid !== prev) begin
        n_err++; rbad++;
        if (rbad < 4)
          $display("FAIL cont_rvalid c=%0d got=%b exp=%b", c,
                   cpu_rvalid, prev);
      end
      if (prev) begin
        n_vec++;
        if (cpu_rdata !== 19'h12345) begin
          n_err++; dbad++;
          if (dbad < 4)
            $display("FAIL cont_rdata c=%0d got=%h exp=12345", c, cpu_rdata);
        end
      end
      prev = exp_g;
      if (done) begin
        dn++;
        if (da == 0) da = c;
      end
      if (da != 0 && c > da) break;
    end
    cpu_req = 1'b0;
    n_vec++;
    if (n !== 88 || da !== 89 || dn !== 1) begin
      n_err++;
      $display("FAIL cont_timing busy=%0d done=%0d cnt=%0d exp 88/89/1",
               n, da, dn);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (mem[19'h800 + 19'(i)] !== 19'h1999A) begin
        n_err++;
        $display("FAIL cont_word%0d got=%h exp=1999a", i,
                 mem[19'h800 + 19'(i)]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int b, da, dn;
    poke(19'h503, 19'h0ABCD);
    @(posedge clk); #1;
    start = 1'b1; op = 2'b11; src = 19'h200; dst = 19'h500;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL mid_busy_before got=%b exp=1", busy);
    end
    rst_n = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h503;
    cpu_wdata = 19'h11111;
    #1;
    n_vec++;
    if ({busy, done, mem_en, cpu_rvalid, cpu_gnt} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset_outputs got=%b exp=00000",
               {busy, done, mem_en, cpu_rvalid, cpu_gnt});
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (mem[19'h500 + 19'(i)] !== 19'(i + 1)) begin
        n_err++;
        $display("FAIL mid_kept%0d got=%h exp=%h", i,
                 mem[19'h500 + 19'(i)], 19'(i + 1));
      end
    end
    n_vec++;
    if (mem[19'h503] !== 19'h0ABCD) begin
      n_err++;
      $display("FAIL mid_untouched got=%h exp=0abcd", mem[19'h503]);
    end
    rst_n = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    run_op(2'b11, 19'h200, 19'hA00, 1'b0, b, da, dn);
    n_vec++;
    if (da !== 25 || dn !== 1) begin
      n_err++;
      $display("FAIL mid_restart done=%0d cnt=%0d exp 25/1", da, dn);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (mem[19'hA00 + 19'(i)] !== 19'(i + 1)) begin
        n_err++;
        $display("FAIL mid_copy%0d got=%h exp=%h", i,
                 mem[19'hA00 + 19'(i)], 19'(i + 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_inc();
    test_wrap();
    test_enc_dec();
    test_start_ignored();
    test_contention();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/blkop_seq.md
Name: blkop_seq

Overview:
- Multi-cycle sequencer for the CPU's block memory operations: increment, XOR-encrypt, XOR-decrypt and copy over LEN-word blocks.
- Walks the words one at a time through a single-port synchronous data memory.
- Shares that memory port with the CPU load/store path. The CPU has priority, and a starvation counter guarantees the engine forward progress.

Parameters:
- DW, 19, data word width
- AW, 19, memory address width
- LEN, 8, words per block operation
- KEY, 19'h1999F, XOR key used by encrypt and decrypt
- STARVE, 4, consecutive denied engine cycles before the engine is forced one grant

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  start request, sampled in IDLE only
- op  in  2  operation: 00 INC (+1), 01 ENC (^KEY), 10 DEC (^KEY), 11 COPY
- src  in  AW  source block base address, latched on accepted start
- dst  in  AW  destination block base address, latched on accepted start
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- cpu_req  in  1  CPU memory access request
- cpu_we  in  1  CPU write enable
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_gnt  out  1  CPU access accepted this cycle (combinational)
- cpu_rdata  out  DW  CPU read data (mem_rdata passthrough)
- cpu_rvalid  out  1  cpu_rdata valid; the cycle after a granted CPU read
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid one cycle after an accepted read

Behaviour:
- Reset (rst_n low, async): state IDLE, index 0, starve count 0. All outputs 0, including busy, done, cpu_rvalid, mem_en and mem_we. Reset mid-operation aborts the operation immediately. No done pulse is issued. Memory is untouched after the reset edge.
- States: IDLE, RD, CAP, WR, DONE.
  - IDLE: start=1 latches op, src and dst, clears the index, and moves to RD. start in any other state is ignored.
  - RD: engine requests a read of src+idx. If granted, go to CAP; otherwise stay in RD.
  - CAP: register the transformed word from mem_rdata. INC: rdata+1 modulo 2^DW (0x7FFFF becomes 0). ENC/DEC: rdata^KEY. COPY: rdata. Engine makes no memory request. Always go to WR.
  - WR: engine requests a write of the transformed word to dst+idx. If granted: if idx==LEN-1 go to DONE, else idx+1 and go to RD. If not granted, stay in WR.
  - DONE: done=1 for exactly one cycle. Go to IDLE.
- busy=1 in RD, CAP and WR; busy=0 in IDLE and DONE.
- Address arithmetic (src+idx, dst+idx) wraps modulo 2^AW.
- Arbitration (combinational, per cycle):
  - Engine requests only in RD and WR.
  - force = (starve count == STARVE) and engine requesting.
  - cpu_gnt = cpu_req & ~force.
  - The engine is granted when it requests and cpu_gnt=0.
- Starvation counter:
  - Increments each cycle the engine requests and is denied.
  - Clears when the engine is granted or leaves RD/WR.
  - Saturates at STARVE.
- Memory port:
  - Granted party drives mem_en=1 with its own mem_we, mem_addr and mem_wdata.
  - No grant: mem_en=0, mem_we=0, other mem outputs 0.
  - A CPU read during the engine's CAP cycle is legal because the port is free.
- cpu_rvalid=1 exactly one cycle after a granted CPU read (cpu_gnt & ~cpu_we). The cycle after an engine read, cpu_rvalid=0.
- Uncontended latency: start in IDLE at cycle T gives busy high T+1..T+3*LEN, done high at T+3*LEN+1, IDLE at T+3*LEN+2. With LEN=8: busy T+1..T+24, done at T+25.
- Overlapping or in-place blocks (src==dst) are processed word-ascending, with no further ordering guarantee.
- No coherence with CPU writes to in-flight addresses; software must not touch the block while busy=1.

Test Plan:
- Preload mem[0x100..0x107]=0..7, op=00, src=0x100, dst=0x200, no CPU traffic -> mem[0x200..0x207]=1..8; busy high 24 cycles; done pulses at T+25.
- ENC src=0x100 (value 0x00005) to dst=0x300, then DEC 0x300 to 0x400 -> mem[0x300]=0x1999A; mem[0x400]=0x00005 for all 8 words.
- INC with mem[src]=0x7FFFF and src=0x7FFFC -> dst word0=0x00000; reads cover 0x7FFFC..0x7FFFF then wrap to 0x00000..0x00003.
- cpu_req held high with reads throughout ENC -> engine granted every STARVE+1=5th request cycle; cpu_gnt low only on those cycles; cpu_rvalid follows each CPU grant by one cycle; final memory contents still correct.
- start pulsed again at T+5 and at T+25 (DONE) -> both ignored; exactly one done pulse; op/src/dst unchanged.
- rst_n low at T+10 mid-COPY -> busy, done, mem_en and cpu_rvalid 0 immediately; words already written remain; after release, a new start completes normally.
